conv_window_sched: RTL and testbench
====================================

Name: conv_window_sched

Overview:
- Sequencer for the convolution input-window buffer and the MAC array behind it.
- Per output tile, walks kernel rows 0..KER-1 and kernel columns 0..KER-1.
- Requests feature-map rows from the line memory and pulses the buffer load enable.
- Issues one MAC beat per (ker_row, ker_col) under a valid/ready handshake and marks tile start/end for the accumulators.

Parameters:
KER, 5, kernel height/width; ker_row/ker_col range 0..KER-1
S1_CODE, 4'd1, cur_state encoding for first conv layer
S2_CODE, 4'd2, cur_state encoding for second conv layer
NT1, 7, output tiles per run for S1_CODE
NT2, 16, output tiles per run for S2_CODE

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
start  in  1  run request; sampled only in IDLE
layer  in  4  S1_CODE or S2_CODE; latched on accepted start
rd_ack  in  1  line memory: in_1/in_2 valid this cycle
mac_ready  in  1  MAC array accepts beat
rd_req  out  1  line-memory fetch request
rd_tile  out  5  tile index of fetch
rd_row  out  4  kernel row of fetch
buf_en  out  1  window-buffer load enable, one-cycle pulse
cur_state  out  4  latched layer code; 0 in IDLE
ker_row  out  4  current kernel row
ker_col  out  4  current kernel column
mac_valid  out  1  MAC beat valid
mac_clear  out  1  first beat of tile (with mac_valid)
mac_last  out  1  last beat of tile (with mac_valid)
busy  out  1  high outside IDLE
done  out  1  one-cycle pulse at run end

Behaviour:
- Reset: FSM=IDLE; all outputs 0; tile, row and column counters 0.
- Reset mid-run: run is abandoned; no done pulse.
- States: IDLE, FETCH, LOAD, COMPUTE, FIN.
- IDLE:
  - start=1 with layer in {S1_CODE, S2_CODE}: latch layer; NT_sel = NT1 or NT2; go FETCH next cycle.
  - start with any other layer code: ignored; stay IDLE.
- FETCH:
  - rd_req=1, rd_tile=tile, rd_row=ker_row.
  - Remain while rd_ack=0; rd_req held high.
  - rd_ack=1 -> LOAD. rd_ack may arrive in the first FETCH cycle.
  - rd_ack outside FETCH is ignored.
- LOAD:
  - Exactly one cycle; buf_en=1; ker_col reset to 0; -> COMPUTE.
- COMPUTE:
  - mac_valid=1 every cycle.
  - Beat accepted when mac_valid & mac_ready.
  - ker_col increments on accept; holds (with all MAC outputs stable) while mac_ready=0.
  - mac_clear=1 when ker_row=0 & ker_col=0.
  - mac_last=1 when ker_row=KER-1 & ker_col=KER-1.
  - On accept with ker_col=KER-1:
    - ker_row<KER-1: ker_row++ -> FETCH.
    - ker_row=KER-1, tile<NT_sel-1: ker_row=0, tile++ -> FETCH.
    - ker_row=KER-1, tile=NT_sel-1: -> FIN.
- FIN: done=1 for one cycle; counters cleared; -> IDLE.
- busy = (state != IDLE).
- cur_state holds the latched code from the cycle after start through FIN; returns to 0 in IDLE.
- Latency, rd_ack same cycle as rd_req, mac_ready constant 1:
  - 1 FETCH + 1 LOAD + KER COMPUTE = KER+2 cycles per row.
  - KER*(KER+2) cycles per tile; 35 at KER=5.
  - Run = 1 (IDLE accept) + NT*35 + 1 (FIN).
- Counter widths: tile 5 bits, row/col 4 bits. Counters never exceed NT-1 / KER-1; no wrap-around beyond that.
- Single driver per output: outputs are decoded from state and counters (registered or decoded consistently); no glitch requirements beyond synchronous sampling.

Test Plan:
- Reset then start=1, layer=S1_CODE, rd_ack tied to rd_req, mac_ready=1 -> busy rises next cycle; exactly 7*25=175 mac_valid beats; 7 mac_clear and 7 mac_last; 35 buf_en pulses; done once, 247 cycles after start; cur_state=1 throughout the run.
- layer=S2_CODE, same stimulus -> 400 beats, 16 tiles, rd_tile sequence 0..15, each tile repeated for rd_row 0..4; done once.
- rd_ack delayed 3 cycles after each rd_req -> rd_req held 4 cycles per fetch; buf_en exactly one cycle after ack; beat count unchanged.
- mac_ready deasserted for 2 cycles at ker_row=2, ker_col=3 -> mac_valid stays 1 with ker_col=3 held; no skipped or duplicated columns.
- start with layer=4'd7 -> stays IDLE, busy=0. start pulsed mid-run -> ignored; run completes normally.
- rst asserted at tile 3, ker_row 1 -> next cycle all outputs 0, no done pulse. A fresh start then runs from tile 0, ker_row 0.

Source files
------------

// File: rtl/conv_window_sched.sv
// conv_window_sched: walks kernel rows/cols per output tile, fetching rows and issuing MAC beats.
module conv_window_sched #(
  parameter int KER = 5,
  parameter logic [3:0] S1_CODE = 4'd1,
  parameter logic [3:0] S2_CODE = 4'd2,
  parameter int NT1 = 7,
  parameter int NT2 = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [3:0] layer,
  input  logic       rd_ack,
  input  logic       mac_ready,
  output logic       rd_req,
  output logic [4:0] rd_tile,
  output logic [3:0] rd_row,
  output logic       buf_en,
  output logic [3:0] cur_state,
  output logic [3:0] ker_row,
  output logic [3:0] ker_col,
  output logic       mac_valid,
  output logic       mac_clear,
  output logic       mac_last,
  output logic       busy,
  output logic       done
);
  typedef enum logic [2:0] {IDLE, FETCH, LOAD, COMPUTE, FIN} state_t;
  localparam logic [3:0] KM = 4'(KER - 1);
  state_t state, state_n;
  logic [4:0] tile, tile_n, tile_max;
  logic [3:0] row, row_n, col, col_n, code, code_n;
  logic col_end, row_end;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      tile  <= '0;
      row   <= '0;
      col   <= '0;
      code  <= '0;
    end else begin
      state <= state_n;
      tile  <= tile_n;
      row   <= row_n;
      col   <= col_n;
      code  <= code_n;
    end
  end
  always_comb begin
    tile_max = (code == S2_CODE) ? 5'(NT2 - 1) : 5'(NT1 - 1);
    col_end  = col == KM;
    row_end  = row == KM;
    state_n  = state;
    tile_n   = tile;
    row_n    = row;
    col_n    = col;
    code_n   = code;
    case (state)
      IDLE: if (start && (layer == S1_CODE || layer == S2_CODE)) begin
        code_n  = layer;
        state_n = FETCH;
      end
      FETCH: state_n = rd_ack ? LOAD : FETCH;
      LOAD: begin
        col_n   = '0;
        state_n = COMPUTE;
      end
      COMPUTE: if (mac_ready) begin
        col_n = col_end ? 4'd0 : col + 4'd1;
        // end of a kernel row: next row, next tile, or finish the run
        if (col_end && !row_end) begin
          row_n   = row + 4'd1;
          state_n = FETCH;
        end else if (col_end && tile != tile_max) begin
          row_n   = '0;
          tile_n  = tile + 5'd1;
          state_n = FETCH;
        end else if (col_end) begin
          state_n = FIN;
        end
      end
      FIN: begin
        tile_n  = '0;
        row_n   = '0;
        col_n   = '0;
        code_n  = '0;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end
  assign rd_req    = state == FETCH;
  assign rd_tile   = rd_req ? tile : 5'd0;
  assign rd_row    = rd_req ? row : 4'd0;
  assign buf_en    = state == LOAD;
  assign cur_state = code;
  assign ker_row   = row;
  assign ker_col   = col;
  assign mac_valid = state == COMPUTE;
  assign mac_clear = mac_valid && row == 4'd0 && col == 4'd0;
  assign mac_last  = mac_valid && row_end && col_end;
  assign busy      = state != IDLE;
  assign done      = state == FIN;
endmodule

// File: tb/tb_conv_window_sched.sv
// tb_conv_window_sched: scoreboard bench; expected fetches, beats and done times come from a nested-loop model.
module tb_conv_window_sched;
  logic clk = 0, rst = 1, start = 0, rd_ack = 0, mac_ready = 1;
  logic [3:0] layer = 0;
  logic rd_req, buf_en, mac_valid, mac_clear, mac_last, busy, done;
  logic [4:0] rd_tile;
  logic [3:0] rd_row, cur_state, ker_row, ker_col;
  logic [27:0] all_out;
  conv_window_sched dut (
    .clk(clk), .rst(rst), .start(start), .layer(layer), .rd_ack(rd_ack),
    .mac_ready(mac_ready), .rd_req(rd_req), .rd_tile(rd_tile), .rd_row(rd_row),
    .buf_en(buf_en), .cur_state(cur_state), .ker_row(ker_row), .ker_col(ker_col),
    .mac_valid(mac_valid), .mac_clear(mac_clear), .mac_last(mac_last),
    .busy(busy), .done(done)
  );
  assign all_out = {rd_req, rd_tile, rd_row, buf_en, cur_state, ker_row, ker_col,
                    mac_valid, mac_clear, mac_last, busy, done};
  always #5 clk = ~clk;
  int total = 0, bad = 0, cyc = 0;
  logic [8:0]  fetch_q[$];
  logic [13:0] beat_q[$];
  int done_q[$];
  int ack_dly = 0, exp_req_len = -1;
  bit ack_rand = 0, rdy_rand = 0, stall_en = 0;
  int n_beat = 0, n_clr = 0, n_last = 0, n_buf = 0, done_cnt = 0;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask
  // line-memory responder: acks after a per-fetch delay
  initial begin
    int fcnt, d;
    fcnt = 0;
    d = 0;
    forever begin
      @(posedge clk);
      #2;
      if (rd_req) begin
        if (fcnt == 0) d = ack_rand ? int'($urandom_range(0, 3)) : ack_dly;
        rd_ack = fcnt >= d;
        fcnt++;
      end else begin
        rd_ack = 0;
        fcnt = 0;
      end
    end
  end
  initial begin
    int hold;
    hold = 0;
    forever begin
      @(posedge clk);
      #2;
      if (stall_en && mac_valid && ker_row == 2 && ker_col == 3 && hold < 2) begin
        mac_ready = 0;
        hold++;
      end else begin
        mac_ready = rdy_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
        if (!(ker_row == 2 && ker_col == 3)) hold = 0;
      end
    end
  end
  // monitor
  initial begin
    logic exp_buf, stl_v;
    logic [13:0] stl_val, got;
    int req_len, e;
    exp_buf = 0;
    stl_v = 0;
    stl_val = 0;
    req_len = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        exp_buf = 0;
        stl_v = 0;
        req_len = 0;
      end else begin
        got = {cur_state, ker_row, ker_col, mac_clear, mac_last};
        if (buf_en) n_buf++;
        if (buf_en || exp_buf) chk("buf_en_after_ack", buf_en, exp_buf);
        exp_buf = rd_req && rd_ack;
        if (rd_req) req_len++;
        if (rd_req && rd_ack) begin
          chk("fetch_expected", fetch_q.size() != 0, 1);
          if (fetch_q.size() != 0) chk("fetch_tile_row", {rd_tile, rd_row}, fetch_q.pop_front());
          if (exp_req_len >= 0) chk("rd_req_len", req_len, exp_req_len);
          req_len = 0;
        end
        if (stl_v) chk("stall_hold", {mac_valid, got}, {1'b1, stl_val});
        stl_v = mac_valid && !mac_ready;
        stl_val = got;
        if (mac_valid && mac_ready) begin
          n_beat++;
          n_clr += int'(mac_clear);
          n_last += int'(mac_last);
          chk("beat_expected", beat_q.size() != 0, 1);
          if (beat_q.size() != 0) chk("beat", got, beat_q.pop_front());
        end
        if (done) begin
          done_cnt++;
          chk("done_expected", done_q.size() != 0, 1);
          if (done_q.size() != 0) begin
            e = done_q.pop_front();
            if (e >= 0) chk("run_len", cyc, e);
          end
        end
      end
    end
  end
  task automatic run_start(input logic [3:0] code, input bit timed);
    int nt = (code == 4'd2) ? 16 : 7;
    for (int t = 0; t < nt; t++)
      for (int r = 0; r < 5; r++) begin
        fetch_q.push_back({5'(t), 4'(r)});
        for (int c = 0; c < 5; c++)
          beat_q.push_back({code, 4'(r), 4'(c), r == 0 && c == 0, r == 4 && c == 4});
      end
    n_beat = 0; n_clr = 0; n_last = 0; n_buf = 0;
    @(posedge clk);
    #2;
    start = 1;
    layer = code;
    done_q.push_back(timed ? cyc + nt * 35 + 1 : -1);
    @(negedge clk);
    chk("busy_before_accept", busy, 0);
    @(posedge clk);
    #2;
    start = 0;
    layer = 4'($urandom);
    @(negedge clk);
    chk("busy_rise", busy, 1);
    chk("cur_state_latched", cur_state, code);
  endtask
  task automatic wait_done(input int budget);
    int d0 = done_cnt;
    for (int i = 0; i < budget && done_cnt == d0; i++) @(posedge clk);
    repeat (3) @(negedge clk);
    chk("done_once", done_cnt - d0, 1);
    chk("beats_drained", beat_q.size(), 0);
    chk("fetch_drained", fetch_q.size(), 0);
    chk("idle_busy", busy, 0);
    chk("idle_cur_state", cur_state, 0);
  endtask
  initial begin
    int d0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_outputs", all_out, 0);
    @(posedge clk);
    #2;
    rst = 0;
    @(negedge clk);
    chk("post_reset_outputs", all_out, 0);
    // S1 nominal
    run_start(4'd1, 1);
    wait_done(600);
    chk("s1_beats", n_beat, 175);
    chk("s1_clears", n_clr, 7);
    chk("s1_lasts", n_last, 7);
    chk("s1_buf_en", n_buf, 35);
    // S2 nominal
    run_start(4'd2, 1);
    wait_done(1200);
    chk("s2_beats", n_beat, 400);
    chk("s2_lasts", n_last, 16);
    // delayed ack
    ack_dly = 3;
    exp_req_len = 4;
    run_start(4'd1, 0);
    wait_done(1500);
    chk("dly_beats", n_beat, 175);
    chk("dly_buf_en", n_buf, 35);
    ack_dly = 0;
    exp_req_len = -1;
    // MAC stall plus ignored mid-run start
    stall_en = 1;
    run_start(4'd1, 0);
    repeat (50) @(posedge clk);
    #2;
    start = 1;
    layer = 4'd2;
    @(posedge clk);
    #2;
    start = 0;
    wait_done(1500);
    chk("stall_beats", n_beat, 175);
    stall_en = 0;
    // randomized handshakes
    ack_rand = 1;
    rdy_rand = 1;
    run_start(4'd2, 0);
    wait_done(5000);
    chk("rand_beats", n_beat, 400);
    run_start(4'd1, 0);
    wait_done(3000);
    chk("rand_s1_clears", n_clr, 7);
    ack_rand = 0;
    rdy_rand = 0;
    // invalid layer code
    @(posedge clk);
    #2;
    start = 1;
    layer = 4'd7;
    repeat (3) @(posedge clk);
    #2;
    start = 0;
    @(negedge clk);
    chk("bad_layer_busy", busy, 0);
    chk("bad_layer_outputs", all_out, 0);
    // reset mid-run at tile 3, row 1
    run_start(4'd1, 0);
    for (int i = 0; i < 2000 && !(rd_req && rd_tile == 5'd3 && rd_row == 4'd1); i++) @(negedge clk);
    chk("reached_t3_r1", {rd_tile, rd_row}, {5'd3, 4'd1});
    d0 = done_cnt;
    @(posedge clk);
    #2;
    rst = 1;
    @(posedge clk);
    #2;
    rst = 0;
    fetch_q.delete();
    beat_q.delete();
    done_q.delete();
    @(negedge clk);
    chk("abort_outputs", all_out, 0);
    repeat (10) @(negedge clk);
    chk("abort_no_done", done_cnt - d0, 0);
    run_start(4'd1, 1);
    wait_done(600);
    chk("rerun_beats", n_beat, 175);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
